mmm_stream_tx: RTL and testbench

- AXI-Stream transmitter that drives the matrix-multiply unit's input stream: it is the producer end of the {TDATA, TVALID, TUSER, TREADY} interface that the MMM input memories consume.
- The host preloads A (M x K) and B (K x N) into local buffers, then issues start. The block streams A (optional) then B in row-major order and tags every beat with K and the new-A flag on TUSER.
- Used as the on-chip source in system builds and as the reusable stimulus driver in MMM benches.

---
 rtl/mmm_stream_tx.sv | 157 +++++++++++++++
 tb/tb_mmm_stream_tx.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/mmm_stream_tx.sv
// AXI-Stream producer for the MMM input path: streams buffered A (optional) then B, row-major, tagged with {K, new_A}.
// Optional AXIS_TLAST output is compiled in when MMM_STREAM_TX_TLAST_EN is defined.
module mmm_stream_tx #(
  parameter int INW  = 12,
  parameter int M    = 7,
  parameter int N    = 9,
  parameter int MAXK = 8
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [INW-1:0]                wr_data,
  input  logic                          a_wr_en,
  input  logic [$clog2(M*MAXK)-1:0]     a_wr_addr,
  input  logic                          b_wr_en,
  input  logic [$clog2(MAXK*N)-1:0]     b_wr_addr,
  input  logic                          start,
  input  logic [$clog2(MAXK+1)-1:0]     start_k,
  input  logic                          start_new_a,
  output logic                          busy,
  output logic                          done,
  output logic                          start_err,
  output logic [INW-1:0]                AXIS_TDATA,
  output logic                          AXIS_TVALID,
  output logic [$clog2(MAXK+1):0]       AXIS_TUSER,
  input  logic                          AXIS_TREADY
`ifdef MMM_STREAM_TX_TLAST_EN
  ,
  output logic                          AXIS_TLAST
`endif
);

  localparam int K_BITS = $clog2(MAXK+1);
  localparam int AW     = $clog2(M*MAXK);
  localparam int BW     = $clog2(MAXK*N);
  localparam int CW     = (AW > BW) ? AW : BW;

  typedef enum logic [1:0] {IDLE, SEND_A, SEND_B, DONE} state_t;

  state_t            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [K_BITS:0]   tuser_q, tuser_d;
  logic [INW-1:0]    tdata_q, tdata_d;
  logic              tvalid_q, tvalid_d;
  logic              done_q, done_d;
  logic              err_q, err_d;

  logic [INW-1:0]    a_mem [M*MAXK];
  logic [INW-1:0]    b_mem [MAXK*N];

  logic [K_BITS-1:0] k_cur;
  logic [CW-1:0]     a_last, b_last;
  logic              ld, ld_a;
  logic [CW-1:0]     ld_idx;

  assign busy   = (state_q == SEND_A) || (state_q == SEND_B);
  assign k_cur  = tuser_q[K_BITS:1];
  assign a_last = CW'(M) * CW'(k_cur) - CW'(1);
  assign b_last = CW'(N) * CW'(k_cur) - CW'(1);

  always_ff @(posedge clk) begin
    if (!busy) begin
      if (a_wr_en) a_mem[a_wr_addr] <= wr_data;
      if (b_wr_en) b_mem[b_wr_addr] <= wr_data;
    end
  end

  // cnt_q is the index of the element currently held in the output register
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    tuser_d  = tuser_q;
    tdata_d  = tdata_q;
    tvalid_d = tvalid_q;
    done_d   = 1'b0;
    err_d    = 1'b0;
    ld       = 1'b0;
    ld_a     = 1'b0;
    ld_idx   = '0;
    case (state_q)
      IDLE: begin
        if (start) begin
          if (start_k == '0 || start_k > K_BITS'(MAXK)) begin
            err_d = 1'b1;
          end else begin
            tuser_d  = {start_k, start_new_a};
            tvalid_d = 1'b1;
            cnt_d    = '0;
            ld       = 1'b1;
            ld_a     = start_new_a;
            state_d  = start_new_a ? SEND_A : SEND_B;
          end
        end
      end
      SEND_A: begin
        if (AXIS_TREADY) begin
          ld = 1'b1;
          if (cnt_q == a_last) begin
            cnt_d   = '0;
            state_d = SEND_B;
          end else begin
            ld_a   = 1'b1;
            ld_idx = cnt_q + CW'(1);
            cnt_d  = cnt_q + CW'(1);
          end
        end
      end
      SEND_B: begin
        if (AXIS_TREADY) begin
          if (cnt_q == b_last) begin
            tvalid_d = 1'b0;
            done_d   = 1'b1;
            state_d  = DONE;
          end else begin
            ld     = 1'b1;
            ld_idx = cnt_q + CW'(1);
            cnt_d  = cnt_q + CW'(1);
          end
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (ld) tdata_d = ld_a ? a_mem[ld_idx[AW-1:0]] : b_mem[ld_idx[BW-1:0]];
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      tuser_q  <= '0;
      tdata_q  <= '0;
      tvalid_q <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      tuser_q  <= tuser_d;
      tdata_q  <= tdata_d;
      tvalid_q <= tvalid_d;
      done_q   <= done_d;
      err_q    <= err_d;
    end
  end

  assign AXIS_TDATA  = tdata_q;
  assign AXIS_TVALID = tvalid_q;
  assign AXIS_TUSER  = tuser_q;
  assign done        = done_q;
  assign start_err   = err_q;

`ifdef MMM_STREAM_TX_TLAST_EN
  // Derived from held state, so it is stable across a stall exactly like TDATA
  assign AXIS_TLAST = (state_q == SEND_B) && (cnt_q == b_last);
`endif

endmodule

// File: tb/tb_mmm_stream_tx.sv
// Randomized self-checking bench for mmm_stream_tx; expected beats come from a queue built from the buffer contents.
module tb_mmm_stream_tx;

  localparam int INW    = 12;
  localparam int M      = 7;
  localparam int N      = 9;
  localparam int MAXK   = 8;
  localparam int K_BITS = $clog2(MAXK+1);
  localparam int AW     = $clog2(M*MAXK);
  localparam int BW     = $clog2(MAXK*N);

  logic              clk, reset;
  logic [INW-1:0]    wr_data;
  logic              a_wr_en, b_wr_en;
  logic [AW-1:0]     a_wr_addr;
  logic [BW-1:0]     b_wr_addr;
  logic              start, start_new_a;
  logic [K_BITS-1:0] start_k;
  logic              busy, done, start_err;
  logic [INW-1:0]    AXIS_TDATA;
  logic              AXIS_TVALID, AXIS_TREADY;
  logic [K_BITS:0]   AXIS_TUSER;
`ifdef MMM_STREAM_TX_TLAST_EN
  logic              AXIS_TLAST;
`endif

  int errors = 0;
  int checks = 0;
  int a_ref [M*MAXK];
  int b_ref [MAXK*N];

  mmm_stream_tx #(.INW(INW), .M(M), .N(N), .MAXK(MAXK)) dut (
    .clk(clk), .reset(reset), .wr_data(wr_data),
    .a_wr_en(a_wr_en), .a_wr_addr(a_wr_addr),
    .b_wr_en(b_wr_en), .b_wr_addr(b_wr_addr),
    .start(start), .start_k(start_k), .start_new_a(start_new_a),
    .busy(busy), .done(done), .start_err(start_err),
    .AXIS_TDATA(AXIS_TDATA), .AXIS_TVALID(AXIS_TVALID),
    .AXIS_TUSER(AXIS_TUSER), .AXIS_TREADY(AXIS_TREADY)
`ifdef MMM_STREAM_TX_TLAST_EN
    , .AXIS_TLAST(AXIS_TLAST)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  // mode 0: A=1.., B=100..; mode 1: random; mode 2: A random, B=0..
  task automatic fill_refs(input int mode);
    for (int i = 0; i < M*MAXK; i++)
      a_ref[i] = (mode == 0) ? i + 1 : int'($urandom_range(0, 4095));
    for (int i = 0; i < MAXK*N; i++)
      b_ref[i] = (mode == 0) ? 100 + i : (mode == 2) ? i : int'($urandom_range(0, 4095));
  endtask

  task automatic write_bufs();
    for (int i = 0; i < M*MAXK; i++) begin
      a_wr_en = 1'b1; a_wr_addr = AW'(i); wr_data = INW'(a_ref[i]);
      @(negedge clk);
    end
    a_wr_en = 1'b0;
    for (int i = 0; i < MAXK*N; i++) begin
      b_wr_en = 1'b1; b_wr_addr = BW'(i); wr_data = INW'(b_ref[i]);
      @(negedge clk);
    end
    b_wr_en = 1'b0;
  endtask

  task automatic run_xfer(input int k, input bit new_a, input int rdy_pct,
                          input int stall_at, input int stall_len, input bit noise);
    int exp_q[$];
    int total, beat, cyc, stalled, budget, exp_user;
    bit hs;
    exp_q = {};
    if (new_a) for (int i = 0; i < M*k; i++) exp_q.push_back(a_ref[i]);
    for (int i = 0; i < k*N; i++) exp_q.push_back(b_ref[i]);
    total    = exp_q.size();
    exp_user = k * 2 + int'(new_a);
    start_k = K_BITS'(k); start_new_a = new_a; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    beat = 0; cyc = 0; stalled = 0; budget = total * 30 + 100;
    while (beat < total && cyc < budget) begin
      chk("tvalid", int'(AXIS_TVALID), 1);
      chk("busy", int'(busy), 1);
      chk("tdata", int'(AXIS_TDATA), exp_q[beat] & 4095);
      chk("tuser", int'(AXIS_TUSER), exp_user);
      chk("no_done", int'(done), 0);
      chk("no_err", int'(start_err), 0);
`ifdef MMM_STREAM_TX_TLAST_EN
      chk("tlast", int'(AXIS_TLAST), int'(beat == total - 1));
`endif
      if (beat == stall_at && stalled < stall_len) begin
        AXIS_TREADY = 1'b0;
        stalled++;
      end else begin
        AXIS_TREADY = ($urandom_range(1, 100) <= rdy_pct);
      end
      hs = AXIS_TVALID && AXIS_TREADY;
      if (noise && busy) begin
        start = ($urandom_range(0, 3) == 0); start_k = K_BITS'($urandom);
        a_wr_en = 1'b1; a_wr_addr = AW'($urandom_range(0, M*MAXK-1));
        b_wr_en = 1'b1; b_wr_addr = BW'($urandom_range(0, MAXK*N-1));
        wr_data = INW'($urandom);
      end else begin
        start = 1'b0; a_wr_en = 1'b0; b_wr_en = 1'b0;
      end
      @(negedge clk);
      cyc++;
      if (hs) beat++;
    end
    start = 1'b0; a_wr_en = 1'b0; b_wr_en = 1'b0; AXIS_TREADY = 1'b1;
    if (beat < total) begin
      chk("timeout_beats", beat, total);
    end else begin
      chk("done_pulse", int'(done), 1);
      chk("busy_at_done", int'(busy), 0);
      chk("tvalid_at_done", int'(AXIS_TVALID), 0);
      chk("err_at_done", int'(start_err), 0);
      if (rdy_pct == 100 && stall_len == 0) chk("cycles", cyc, total);
    end
    @(negedge clk);
    chk("done_once", int'(done), 0);
    chk("idle_busy", int'(busy), 0);
  endtask

  task automatic bad_start(input int k);
    start_k = K_BITS'(k); start_new_a = 1'b1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("err_pulse", int'(start_err), 1);
    chk("err_busy", int'(busy), 0);
    chk("err_tvalid", int'(AXIS_TVALID), 0);
    @(negedge clk);
    chk("err_once", int'(start_err), 0);
    chk("err_tvalid2", int'(AXIS_TVALID), 0);
  endtask

  initial begin
    reset = 1'b0; wr_data = '0; a_wr_en = 1'b0; b_wr_en = 1'b0;
    a_wr_addr = '0; b_wr_addr = '0; start = 1'b0; start_k = '0;
    start_new_a = 1'b0; AXIS_TREADY = 1'b1;
    #12;
    chk("rst_tvalid", int'(AXIS_TVALID), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_err", int'(start_err), 0);
    chk("rst_tdata", int'(AXIS_TDATA), 0);
    chk("rst_tuser", int'(AXIS_TUSER), 0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);

    fill_refs(0);
    write_bufs();
    run_xfer(2, 1'b1, 100, -1, 0, 1'b0);
    run_xfer(2, 1'b1, 100, 4, 3, 1'b0);

    fill_refs(2);
    write_bufs();
    run_xfer(3, 1'b0, 100, -1, 0, 1'b0);

    bad_start(0);
    bad_start(9);

    fill_refs(1);
    write_bufs();
    start_k = K_BITS'(8); start_new_a = 1'b1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (10) @(negedge clk);
    chk("pre_abort_tdata", int'(AXIS_TDATA), a_ref[10]);
    #2 reset = 1'b0;
    #1;
    chk("abort_tvalid", int'(AXIS_TVALID), 0);
    chk("abort_busy", int'(busy), 0);
    repeat (2) begin
      @(negedge clk);
      chk("abort_no_done", int'(done), 0);
    end
    reset = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("post_abort_done", int'(done), 0);
      chk("post_abort_tvalid", int'(AXIS_TVALID), 0);
    end
    fill_refs(1);
    write_bufs();
    run_xfer(1, 1'b1, 100, -1, 0, 1'b0);

    run_xfer(1, 1'b1, 100, 15, 2, 1'b0);

    for (int r = 0; r < 8; r++) begin
      if (r % 2 == 0) begin
        fill_refs(1);
        write_bufs();
      end
      run_xfer(int'($urandom_range(1, MAXK)), 1'($urandom_range(0, 1)), 60, -1, 0, 1'b1);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
